parallel_to_serial_shifter: RTL



---
 rtl/parallel_to_serial_shifter.sv | 76 +++++++
 1 files changed

// File: rtl/parallel_to_serial_shifter.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it out MSB first, one bit per clock, with back-to-back streaming.
module parallel_to_serial_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;

  // A new word may be taken while idle or on the cycle carrying the last bit.
  assign in_ready = ~rst & ((state == IDLE) | ((state == SHIFT) & (cnt == '0)));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= in_data;
            cnt   <= LAST_CNT;
            state <= SHIFT;
          end else begin
            sreg <= '0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt - CW'(1);
          end else if (accept) begin
            sreg <= in_data;
            cnt  <= LAST_CNT;
          end else begin
            sreg  <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          sreg  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign q       = (state == SHIFT) & sreg[WIDTH-1];
  assign q_valid = (state == SHIFT);
  assign q_last  = (state == SHIFT) & (cnt == '0);

endmodule
